// File: rtl/battle_turn_scheduler.sv
// rtl/battle_turn_scheduler.sv - turn-based combat sequencer between PS/2 key decode and engine_accuracy
// Optional feature macro: TURN_TIMEOUT_EN (forces a default punch after TIMEOUT_CYCLES idle cycles in a SEL state)
module battle_turn_scheduler #(
  parameter int         TIMEOUT_CYCLES = 50_000_000,
  parameter int         CNT_W          = 26,
  parameter logic [7:0] PP             = 8'h1C,
  parameter logic [7:0] PK             = 8'h1B,
  parameter logic [7:0] PB             = 8'h23,
  parameter logic [7:0] PS             = 8'h1D,
  parameter logic [7:0] EP             = 8'h3B,
  parameter logic [7:0] EK             = 8'h42,
  parameter logic [7:0] EB             = 8'h4B,
  parameter logic [7:0] ES             = 8'h43
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       battle_start,
  input  logic       collision_detected,
  input  logic       player_win,
  input  logic       enemy_win,
  input  logic       player_remained_sword,
  input  logic       player_remained_baseballbat,
  input  logic       enemy_remained_sword,
  input  logic       enemy_remained_baseballbat,
  output logic [1:0] player_choice,
  output logic [1:0] enemy_choice,
  output logic       player_turn,
  output logic       attacker_turn,
  output logic       attack_valid,
  output logic       key_reject,
  output logic       timeout_flag,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    P_SEL = 3'd1,
    P_ATK = 3'd2,
    E_SEL = 3'd3,
    E_ATK = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [7:0] BREAK_CODE = 8'hF0;

  state_t     state_q, state_d;
  logic [1:0] player_choice_q, player_choice_d;
  logic [1:0] enemy_choice_q, enemy_choice_d;
  logic       player_turn_q, player_turn_d;
  logic       attacker_turn_q, attacker_turn_d;
  logic       attack_valid_q, attack_valid_d;
  logic       key_reject_q, key_reject_d;
  logic       timeout_flag_q, timeout_flag_d;
  logic       brk_q, brk_d;

  logic       key_ok;
  logic [2:0] p_dec, e_dec, sel_dec;
  logic       sel_left;
  logic       in_sel;
  logic       timeout_hit;

  // Returns {hit, choice} for a scancode against one side's four weapon codes.
  function automatic logic [2:0] decode(input logic [7:0] code, input logic [7:0] c_p,
                                        input logic [7:0] c_k, input logic [7:0] c_b,
                                        input logic [7:0] c_s);
    logic [2:0] r;
    r = 3'b000;
    if (code == c_p)      r = 3'b100;
    else if (code == c_k) r = 3'b101;
    else if (code == c_b) r = 3'b110;
    else if (code == c_s) r = 3'b111;
    return r;
  endfunction

  assign in_sel = (state_q == P_SEL) || (state_q == E_SEL);

`ifdef TURN_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = in_sel && (cnt_q == CNT_LAST);

  // Idle counter: restarts on every state change or rejected key, saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || key_reject_d || !in_sel) cnt_d = '0;
    else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  logic [CNT_W-1:0] unused_timeout_cfg;

  assign unused_timeout_cfg = CNT_W'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
`endif

  // Next-state logic: break filter, key decode, turn ownership and outcome handling.
  always_comb begin
    state_d         = state_q;
    player_choice_d = player_choice_q;
    enemy_choice_d  = enemy_choice_q;
    player_turn_d   = player_turn_q;
    attacker_turn_d = attacker_turn_q;
    attack_valid_d  = 1'b0;
    key_reject_d    = 1'b0;
    timeout_flag_d  = 1'b0;
    brk_d           = brk_q;
    key_ok          = 1'b0;

    // The byte following F0 is the released key and never counts as a press.
    if (key_valid) begin
      if (brk_q)                        brk_d  = 1'b0;
      else if (key_code == BREAK_CODE)  brk_d  = 1'b1;
      else                              key_ok = 1'b1;
    end

    p_dec   = decode(key_code, PP, PK, PB, PS);
    e_dec   = decode(key_code, EP, EK, EB, ES);
    sel_dec = (state_q == E_SEL) ? e_dec : p_dec;

    // Punch and kick never run out; bat and sword depend on the side's remaining uses.
    sel_left = 1'b1;
    if (state_q == E_SEL) begin
      if (sel_dec[1:0] == 2'b10) sel_left = enemy_remained_baseballbat;
      if (sel_dec[1:0] == 2'b11) sel_left = enemy_remained_sword;
    end else begin
      if (sel_dec[1:0] == 2'b10) sel_left = player_remained_baseballbat;
      if (sel_dec[1:0] == 2'b11) sel_left = player_remained_sword;
    end

    case (state_q)
      IDLE: begin
        if (battle_start) begin
          state_d         = P_SEL;
          player_turn_d   = 1'b1;
          attacker_turn_d = 1'b0;
        end
      end
      DONE: begin
        if (!battle_start) state_d = IDLE;
      end
      P_SEL, P_ATK, E_SEL, E_ATK: begin
        if (player_win || enemy_win) begin
          state_d         = DONE;
          player_turn_d   = 1'b0;
          attacker_turn_d = 1'b0;
        end else if (!battle_start) begin
          state_d         = IDLE;
          player_turn_d   = 1'b0;
          attacker_turn_d = 1'b0;
        end else if (state_q == P_ATK || state_q == E_ATK) begin
          if (collision_detected) begin
            state_d         = (state_q == P_ATK) ? E_SEL : P_SEL;
            player_turn_d   = ~player_turn_q;
            attacker_turn_d = ~attacker_turn_q;
          end
        end else if (key_ok && sel_dec[2] && !sel_left) begin
          key_reject_d = 1'b1;
        end else if (key_ok && sel_dec[2]) begin
          attack_valid_d = 1'b1;
          if (state_q == P_SEL) begin
            player_choice_d = sel_dec[1:0];
            state_d         = P_ATK;
          end else begin
            enemy_choice_d  = sel_dec[1:0];
            state_d         = E_ATK;
          end
        end else if (timeout_hit) begin
          attack_valid_d = 1'b1;
          timeout_flag_d = 1'b1;
          if (state_q == P_SEL) begin
            player_choice_d = 2'b00;
            state_d         = P_ATK;
          end else begin
            enemy_choice_d  = 2'b00;
            state_d         = E_ATK;
          end
        end
      end
      default: begin
        state_d         = IDLE;
        player_turn_d   = 1'b0;
        attacker_turn_d = 1'b0;
      end
    endcase
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      player_choice_q <= 2'b00;
      enemy_choice_q  <= 2'b00;
      player_turn_q   <= 1'b0;
      attacker_turn_q <= 1'b0;
      attack_valid_q  <= 1'b0;
      key_reject_q    <= 1'b0;
      timeout_flag_q  <= 1'b0;
      brk_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      player_choice_q <= player_choice_d;
      enemy_choice_q  <= enemy_choice_d;
      player_turn_q   <= player_turn_d;
      attacker_turn_q <= attacker_turn_d;
      attack_valid_q  <= attack_valid_d;
      key_reject_q    <= key_reject_d;
      timeout_flag_q  <= timeout_flag_d;
      brk_q           <= brk_d;
    end
  end

  assign player_choice = player_choice_q;
  assign enemy_choice  = enemy_choice_q;
  assign player_turn   = player_turn_q;
  assign attacker_turn = attacker_turn_q;
  assign attack_valid  = attack_valid_q;
  assign key_reject    = key_reject_q;
  assign timeout_flag  = timeout_flag_q;
  assign state         = state_q;

endmodule

// File: tb/tb_battle_turn_scheduler.sv
// tb/tb_battle_turn_scheduler.sv - directed table, corner sequences and randomized model check for battle_turn_scheduler
module tb_battle_turn_scheduler;

  localparam int TO = 16;
`ifdef TURN_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  localparam logic [2:0] S_IDLE = 3'd0, S_PSEL = 3'd1, S_PATK = 3'd2,
                         S_ESEL = 3'd3, S_EATK = 3'd4, S_DONE = 3'd5;
  localparam logic [3:0] W_ALL = 4'b1111;  // {p_sword, p_bat, e_sword, e_bat}

  typedef struct packed {
    logic       kv;
    logic [7:0] kc;
    logic       bs;
    logic       col;
    logic       pw;
    logic       ew;
    logic [3:0] wpn;
  } in_t;

  typedef struct packed {
    logic [2:0] st;
    logic       pt;
    logic       at;
    logic [1:0] pc;
    logic [1:0] ec;
    logic       av;
    logic       rej;
    logic       tf;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [7:0] key_code;
  logic       battle_start, collision_detected, player_win, enemy_win;
  logic       p_sword, p_bat, e_sword, e_bat;
  logic [1:0] player_choice, enemy_choice;
  logic       player_turn, attacker_turn, attack_valid, key_reject, timeout_flag;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  battle_turn_scheduler #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .key_valid                   (key_valid),
    .key_code                    (key_code),
    .battle_start                (battle_start),
    .collision_detected          (collision_detected),
    .player_win                  (player_win),
    .enemy_win                   (enemy_win),
    .player_remained_sword       (p_sword),
    .player_remained_baseballbat (p_bat),
    .enemy_remained_sword        (e_sword),
    .enemy_remained_baseballbat  (e_bat),
    .player_choice               (player_choice),
    .enemy_choice                (enemy_choice),
    .player_turn                 (player_turn),
    .attacker_turn               (attacker_turn),
    .attack_valid                (attack_valid),
    .key_reject                  (key_reject),
    .timeout_flag                (timeout_flag),
    .state                       (state)
  );

  function automatic in_t mi(input logic kv, input logic [7:0] kc, input logic bs,
                             input logic col, input logic pw, input logic ew, input logic [3:0] wpn);
    in_t r;
    r.kv = kv; r.kc = kc; r.bs = bs; r.col = col; r.pw = pw; r.ew = ew; r.wpn = wpn;
    return r;
  endfunction

  function automatic out_t mo(input logic [2:0] st, input logic pt, input logic at, input logic [1:0] pc,
                              input logic [1:0] ec, input logic av, input logic rej, input logic tf);
    out_t r;
    r.st = st; r.pt = pt; r.at = at; r.pc = pc; r.ec = ec; r.av = av; r.rej = rej; r.tf = tf;
    return r;
  endfunction

  task automatic drive(input in_t i);
    key_valid = i.kv; key_code = i.kc; battle_start = i.bs; collision_detected = i.col;
    player_win = i.pw; enemy_win = i.ew;
    {p_sword, p_bat, e_sword, e_bat} = i.wpn;
  endtask

  task automatic check(input string name, input out_t e);
    out_t g;
    g = mo(state, player_turn, attacker_turn, player_choice, enemy_choice,
           attack_valid, key_reject, timeout_flag);
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s: got st=%0d pt=%0b at=%0b pc=%0d ec=%0d av=%0b rej=%0b tf=%0b, expected st=%0d pt=%0b at=%0b pc=%0d ec=%0d av=%0b rej=%0b tf=%0b",
               name, g.st, g.pt, g.at, g.pc, g.ec, g.av, g.rej, g.tf,
               e.st, e.pt, e.at, e.pc, e.ec, e.av, e.rej, e.tf);
    end
  endtask

  // Called at a negedge: apply inputs for one cycle and check just after the edge.
  task automatic step_check(input string name, input in_t i, input out_t e);
    drive(i);
    @(posedge clk);
    #1;
    check(name, e);
    @(negedge clk);
  endtask

  // ---------------- behavioural reference model ----------------
  out_t m;
  bit   m_brk;
  int   m_wait;

  function automatic int weapon_of(input int side, input logic [7:0] c);
    logic [7:0] codes [4];
    if (side == 0) codes = '{8'h1C, 8'h1B, 8'h23, 8'h1D};
    else           codes = '{8'h3B, 8'h42, 8'h4B, 8'h43};
    for (int k = 0; k < 4; k++) if (codes[k] == c) return k;
    return -1;
  endfunction

  function automatic bit weapon_left(input int side, input int w, input logic [3:0] wpn);
    if (w < 2) return 1'b1;
    if (side == 0) return (w == 3) ? wpn[3] : wpn[2];
    return (w == 3) ? wpn[1] : wpn[0];
  endfunction

  task automatic model_step(input in_t i);
    out_t n;
    bit   keyok;
    int   side;
    int   w;
    n = m; n.av = 0; n.rej = 0; n.tf = 0; keyok = 0;
    if (i.kv) begin
      if (m_brk) m_brk = 0;
      else if (i.kc == 8'hF0) m_brk = 1;
      else keyok = 1;
    end
    if (m.st == S_IDLE) begin
      if (i.bs) begin n.st = S_PSEL; n.pt = 1; n.at = 0; end
    end else if (m.st == S_DONE) begin
      if (!i.bs) n.st = S_IDLE;
    end else if (i.pw || i.ew) begin
      n.st = S_DONE; n.pt = 0; n.at = 0;
    end else if (!i.bs) begin
      n.st = S_IDLE; n.pt = 0; n.at = 0;
    end else if (m.st == S_PATK || m.st == S_EATK) begin
      if (i.col) begin
        n.st = (m.st == S_PATK) ? S_ESEL : S_PSEL;
        n.pt = !m.pt; n.at = !m.at;
      end
    end else begin
      side = (m.st == S_PSEL) ? 0 : 1;
      w = keyok ? weapon_of(side, i.kc) : -1;
      if (w >= 0 && !weapon_left(side, w, i.wpn)) begin
        n.rej = 1;
      end else if (w >= 0 || (TIMEOUT_ON && m_wait == TO - 1)) begin
        if (w < 0) begin w = 0; n.tf = 1; end
        if (side == 0) n.pc = 2'(w); else n.ec = 2'(w);
        n.av = 1;
        n.st = m.st + 3'd1;
      end
    end
    if (n.st != m.st || n.rej || !(n.st == S_PSEL || n.st == S_ESEL)) m_wait = 0;
    else m_wait++;
    m = n;
  endtask

  vec_t dir[$];

  initial begin
    in_t  ri;
    int   r;
    logic [7:0] pick [11];

    // directed table: {inputs, expected outputs after the edge}
    dir.push_back({mi(0, 8'h00, 1, 0, 0, 0, W_ALL), mo(S_PSEL, 1, 0, 0, 0, 0, 0, 0)});
    dir.push_back({mi(1, 8'h1B, 1, 0, 0, 0, W_ALL), mo(S_PATK, 1, 0, 1, 0, 1, 0, 0)});
    dir.push_back({mi(0, 8'h00, 1, 0, 0, 0, W_ALL), mo(S_PATK, 1, 0, 1, 0, 0, 0, 0)});
    dir.push_back({mi(1, 8'h1C, 1, 0, 0, 0, W_ALL), mo(S_PATK, 1, 0, 1, 0, 0, 0, 0)});
    dir.push_back({mi(0, 8'h00, 1, 1, 0, 0, W_ALL), mo(S_ESEL, 0, 1, 1, 0, 0, 0, 0)});
    dir.push_back({mi(1, 8'h43, 1, 0, 0, 0, 4'b1101), mo(S_ESEL, 0, 1, 1, 0, 0, 1, 0)});
    dir.push_back({mi(0, 8'h00, 1, 0, 0, 0, 4'b1101), mo(S_ESEL, 0, 1, 1, 0, 0, 0, 0)});
    dir.push_back({mi(1, 8'h1C, 1, 0, 0, 0, W_ALL), mo(S_ESEL, 0, 1, 1, 0, 0, 0, 0)});
    dir.push_back({mi(1, 8'h4B, 1, 0, 0, 0, W_ALL), mo(S_EATK, 0, 1, 1, 2, 1, 0, 0)});
    dir.push_back({mi(0, 8'h00, 1, 1, 0, 0, W_ALL), mo(S_PSEL, 1, 0, 1, 2, 0, 0, 0)});
    dir.push_back({mi(1, 8'hF0, 1, 0, 0, 0, W_ALL), mo(S_PSEL, 1, 0, 1, 2, 0, 0, 0)});
    dir.push_back({mi(1, 8'h1C, 1, 0, 0, 0, W_ALL), mo(S_PSEL, 1, 0, 1, 2, 0, 0, 0)});
    dir.push_back({mi(1, 8'h1D, 1, 0, 0, 0, W_ALL), mo(S_PATK, 1, 0, 3, 2, 1, 0, 0)});
    dir.push_back({mi(0, 8'h00, 1, 1, 0, 1, W_ALL), mo(S_DONE, 0, 0, 3, 2, 0, 0, 0)});
    dir.push_back({mi(0, 8'h00, 0, 0, 0, 0, W_ALL), mo(S_IDLE, 0, 0, 3, 2, 0, 0, 0)});
    dir.push_back({mi(0, 8'h00, 1, 0, 0, 0, W_ALL), mo(S_PSEL, 1, 0, 3, 2, 0, 0, 0)});
    dir.push_back({mi(1, 8'h55, 1, 0, 0, 0, W_ALL), mo(S_PSEL, 1, 0, 3, 2, 0, 0, 0)});
    dir.push_back({mi(1, 8'h23, 1, 0, 0, 0, 4'b1011), mo(S_PSEL, 1, 0, 3, 2, 0, 1, 0)});
    dir.push_back({mi(1, 8'h42, 1, 0, 0, 0, W_ALL), mo(S_PSEL, 1, 0, 3, 2, 0, 0, 0)});
    dir.push_back({mi(0, 8'h00, 0, 0, 0, 0, W_ALL), mo(S_IDLE, 0, 0, 3, 2, 0, 0, 0)});

    rst = 1'b0;
    drive(mi(0, 8'h00, 0, 0, 0, 0, W_ALL));
    repeat (2) @(posedge clk);
    #1;
    check("reset", '0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < dir.size(); k++)
      step_check($sformatf("dir[%0d]", k), dir[k].i, dir[k].e);

    // asynchronous reset in the middle of an attack
    step_check("ar_start", mi(0, 8'h00, 1, 0, 0, 0, W_ALL), mo(S_PSEL, 1, 0, 3, 2, 0, 0, 0));
    drive(mi(1, 8'h1C, 1, 0, 0, 0, W_ALL));
    @(posedge clk);
    #1;
    check("ar_accept", mo(S_PATK, 1, 0, 0, 2, 1, 0, 0));
    #1 rst = 1'b0;
    #1;
    check("ar_async", '0);
    @(negedge clk);
    rst = 1'b1;
    step_check("ar_resume", mi(0, 8'h00, 1, 0, 0, 0, W_ALL), mo(S_PSEL, 1, 0, 0, 0, 0, 0, 0));

`ifdef TURN_TIMEOUT_EN
    step_check("to_p", mi(1, 8'h1C, 1, 0, 0, 0, W_ALL), mo(S_PATK, 1, 0, 0, 0, 1, 0, 0));
    step_check("to_c1", mi(0, 8'h00, 1, 1, 0, 0, W_ALL), mo(S_ESEL, 0, 1, 0, 0, 0, 0, 0));
    step_check("to_e", mi(1, 8'h42, 1, 0, 0, 0, W_ALL), mo(S_EATK, 0, 1, 0, 1, 1, 0, 0));
    step_check("to_c2", mi(0, 8'h00, 1, 1, 0, 0, W_ALL), mo(S_PSEL, 1, 0, 0, 1, 0, 0, 0));
    step_check("to_p2", mi(1, 8'h1B, 1, 0, 0, 0, W_ALL), mo(S_PATK, 1, 0, 1, 1, 1, 0, 0));
    step_check("to_c3", mi(0, 8'h00, 1, 1, 0, 0, W_ALL), mo(S_ESEL, 0, 1, 1, 1, 0, 0, 0));
    for (int k = 1; k <= TO; k++) begin
      if (k < TO)
        step_check($sformatf("to_wait[%0d]", k), mi(0, 8'h00, 1, 0, 0, 0, W_ALL),
                   mo(S_ESEL, 0, 1, 1, 1, 0, 0, 0));
      else
        step_check("to_fire", mi(0, 8'h00, 1, 0, 0, 0, W_ALL), mo(S_EATK, 0, 1, 1, 0, 1, 0, 1));
    end
    step_check("to_after", mi(0, 8'h00, 1, 0, 0, 0, W_ALL), mo(S_EATK, 0, 1, 1, 0, 0, 0, 0));
`endif

    // randomized run against the reference model, from a fresh reset
    rst = 1'b0;
    drive(mi(0, 8'h00, 0, 0, 0, 0, W_ALL));
    @(posedge clk);
    #1;
    check("rand_reset", '0);
    @(negedge clk);
    rst = 1'b1;
    m = '0; m_brk = 0; m_wait = 0;
    pick = '{8'h1C, 8'h1B, 8'h23, 8'h1D, 8'h3B, 8'h42, 8'h4B, 8'h43, 8'hF0, 8'h55, 8'h00};
    for (int n = 0; n < 3000; n++) begin
      ri.bs  = ($urandom_range(0, 99) >= 3);
      ri.pw  = ($urandom_range(0, 299) == 0);
      ri.ew  = ($urandom_range(0, 299) == 0);
      ri.col = ($urandom_range(0, 3) == 0);
      ri.kv  = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 10);
      ri.kc  = (r == 10) ? 8'($urandom) : pick[r];
      ri.wpn = 4'($urandom);
      if ($urandom_range(0, 1) == 0) ri.wpn = W_ALL;
      model_step(ri);
      step_check($sformatf("rand[%0d]", n), ri, m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/battle_turn_scheduler.md
# battle_turn_scheduler

Sequences the turn-based combat between the PS/2 keyboard front end and `engine_accuracy`. Decodes player and enemy attack keys, accepts only the side whose turn it is, and locks out exhausted weapons. Issues one attack command per turn and alternates turns on each `collision_detected`. Replaces the ad-hoc turn toggling in the top level with a single owner of `player_turn` and `attacker_turn`.

## Interface
- `TIMEOUT_CYCLES`, default 50_000_000: idle cycles in a SELECT state before the default punch is forced (1 s at 50 MHz).
- `CNT_W`, default 26: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- `PP`/`PK`/`PB`/`PS`, defaults 8'h1C/8'h1B/8'h23/8'h1D: player punch/kick/bat/sword scancodes.
- `EP`/`EK`/`EB`/`ES`, defaults 8'h3B/8'h42/8'h4B/8'h43: enemy punch/kick/bat/sword scancodes.
- `clk`  in  1  system clock; the block's only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  one-cycle strobe; `key_code` is a new scancode byte.
- `key_code`  in  8  raw PS/2 byte, including the 8'hF0 break prefix.
- `battle_start`  in  1  level from the engine; a battle is active.
- `collision_detected`  in  1  pulse from the engine; the in-flight attack resolved.
- `player_win`, `enemy_win`  in  1 each  battle outcome levels.
- `player_remained_sword`, `player_remained_baseballbat`  in  1 each  high means the weapon still has uses.
- `enemy_remained_sword`, `enemy_remained_baseballbat`  in  1 each  same, for the enemy.
- `player_choice`  out  2  registered player attack: 00 punch, 01 kick, 10 bat, 11 sword.
- `enemy_choice`  out  2  registered enemy attack, same encoding.
- `player_turn`, `attacker_turn`  out  1 each  one-hot turn indicators.
- `attack_valid`  out  1  one-cycle launch pulse to the engine.
- `key_reject`  out  1  one-cycle pulse when a selected weapon is exhausted.
- `timeout_flag`  out  1  one-cycle pulse when the default punch is forced.
- `state`  out  3  current FSM state, for debug.

## Operation
- States and encodings: IDLE=0, P_SEL=1, P_ATK=2, E_SEL=3, E_ATK=4, DONE=5.
- IDLE → P_SEL when `battle_start`=1. `player_turn` is set to 1 and `attacker_turn` to 0 on entering P_SEL.
- P_SEL:
  - A player scancode is accepted when `key_valid`=1 and the break filter is clear.
  - The code maps to `player_choice`; `attack_valid` pulses, then the FSM goes to P_ATK.
  - A bat (sword) request with `player_remained_baseballbat` (`player_remained_sword`)=0 pulses `key_reject` and stays in P_SEL.
  - Enemy codes and unknown codes are ignored.
- P_ATK → E_SEL on `collision_detected`=1. Both turn bits swap in the same transition. All keys are ignored while in P_ATK.
- E_SEL and E_ATK mirror P_SEL and P_ATK, using the enemy codes and the enemy weapon inputs. E_ATK → P_SEL on collision.
- Break filter:
  - Byte 8'hF0 with `key_valid` sets a one-bit flag.
  - The next `key_valid` byte is discarded and clears the flag.
  - The filter runs in every state.
- Any state except IDLE goes to DONE when `player_win` or `enemy_win` is 1. In DONE, both turn bits are 0.
- DONE → IDLE when `battle_start`=0.
- Any non-IDLE state → IDLE when `battle_start` drops without a win.
- Priority within one cycle: win > `battle_start` drop > collision > key.
- Choices hold their last value until the next accepted key of that side.

## Timing
- Reset values: `state`=IDLE, choices=00, turn bits=0, `attack_valid`=`key_reject`=`timeout_flag`=0, break flag=0, counter=0.
- Key accept latency:
  - `key_valid` at cycle N → `player_choice`/`enemy_choice` and `attack_valid` registered at N+1.
  - The state is P_ATK or E_ATK at N+1.
  - `attack_valid` is high for exactly one cycle.
- Collision at cycle N → new state and swapped turn bits at N+1.
- A key arriving in the same cycle as the collision is dropped; it is not queued.
- Reset asserted mid-battle returns all outputs to reset values immediately (asynchronous). The FSM resumes from IDLE after release.
- Timeout counter:
  - Runs only in P_SEL and E_SEL.
  - Clears on state entry and on `key_reject`.
  - Saturates; it does not wrap.

## Configuration
- `TURN_TIMEOUT_EN` defined:
  - When the counter reaches TIMEOUT_CYCLES-1 in P_SEL or E_SEL, the current side's choice is forced to 00.
  - In the same cycle, `attack_valid` and `timeout_flag` pulse and the FSM advances to the ATK state.
- `TURN_TIMEOUT_EN` undefined:
  - The counter is not built and `timeout_flag` is tied to 0.
  - SEL states wait indefinitely.

## Test plan
- Reset, then `battle_start`=1 → the next cycle shows state=1, `player_turn`=1, `attacker_turn`=0.
- In P_SEL, key 8'h1B → next cycle `player_choice`=01, `attack_valid`=1 for one cycle, state=2. Then a collision pulse → state=3, `player_turn`=0, `attacker_turn`=1.
- In E_SEL with `enemy_remained_sword`=0, key 8'h43 → `key_reject` pulses and state stays 3. Key 8'h4B → `enemy_choice`=10, state=4.
- In P_SEL, send 8'hF0 followed by 8'h1C → no accept. A following 8'h1D → `player_choice`=11.
- In P_ATK, raise `collision_detected` and `enemy_win` together → state=5 and both turn bits are 0. Dropping `battle_start` → state=0.
- With `TURN_TIMEOUT_EN` and TIMEOUT_CYCLES=16, no key in E_SEL → after 16 cycles `enemy_choice`=00 and `timeout_flag`=`attack_valid`=1, state=4.
